// File: rtl/data_mem_responder.sv
// Load/store memory responder: one request at a time, a fixed number of wait states,
// then one RV32I-extended response. Storage is split into four byte lanes.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W     = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    typedef struct packed {
        logic             write;
        logic [2:0]       funct3;
        logic [1:0]       lane;
        logic [IDX_W-1:0] idx;
        logic [31:0]      wdata;
        logic             err;
    } req_t;

    state_t                           r_state, w_nxt_state;
    req_t                             r_req, w_nxt_req;
    logic [CNT_W-1:0]                 r_cnt, w_nxt_cnt;
    logic                             r_req_ready, w_nxt_ready;
    logic                             r_rsp_valid, w_nxt_valid;
    logic [31:0]                      r_rsp_rdata, w_nxt_rdata;
    logic                             r_rsp_error, w_nxt_error;

    logic [31:0]                      w_off;
    logic                             w_oor, w_f3_ok, w_misalign, w_req_err;
    logic                             w_access, w_we;
    logic [NUM_LANES-1:0]             w_be;
    logic [NUM_LANES-1:0][7:0]        w_wlane, w_rlane;
    logic [31:0]                      w_shift, w_load;

    // Request classification happens on the live inputs so the result is latched with them.
    assign w_off      = req_addr - ADDR_BASE;
    assign w_oor      = (req_addr < ADDR_BASE) || ({2'b00, w_off[31:2]} >= 32'(DEPTH_WORDS));
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && w_off[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (w_off[1:0] != 2'b00));
    assign w_req_err  = w_oor || !w_f3_ok || w_misalign;

    always_comb begin
        w_f3_ok = 1'b0;
        case (req_funct3)
            3'd0, 3'd1, 3'd2: w_f3_ok = 1'b1;
            3'd4, 3'd5:       w_f3_ok = !req_write;
            default:          w_f3_ok = 1'b0;
        endcase
    end

    assign w_access = (r_state == S_BUSY) && (r_cnt == '0);
    assign w_we     = w_access && r_req.write && !r_req.err;

    always_comb begin
        w_be    = 4'b1111;
        w_wlane = r_req.wdata;
        case (r_req.funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_req.lane;
                w_wlane = {NUM_LANES{r_req.wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << r_req.lane;
                w_wlane = {2{r_req.wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wlane = r_req.wdata;
            end
        endcase
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (w_we && w_be[g]) r_mem[r_req.idx] <= w_wlane[g];
        end

        assign w_rlane[g] = r_mem[r_req.idx];
    end

    assign w_shift = w_rlane >> {r_req.lane, 3'b000};

    always_comb begin
        w_load = '0;
        if (!r_req.write && !r_req.err) begin
            case (r_req.funct3)
                3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
                3'd1:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
                3'd2:    w_load = w_rlane;
                3'd4:    w_load = {24'h0, w_shift[7:0]};
                3'd5:    w_load = {16'h0, w_shift[15:0]};
                default: w_load = '0;
            endcase
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_req   = r_req;
        w_nxt_cnt   = r_cnt;
        w_nxt_ready = r_req_ready;
        w_nxt_valid = r_rsp_valid;
        w_nxt_rdata = r_rsp_rdata;
        w_nxt_error = r_rsp_error;
        case (r_state)
            S_IDLE: begin
                w_nxt_ready = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_nxt_req.write  = req_write;
                    w_nxt_req.funct3 = req_funct3;
                    w_nxt_req.lane   = w_off[1:0];
                    w_nxt_req.idx    = w_off[IDX_W+1:2];
                    w_nxt_req.wdata  = req_wdata;
                    w_nxt_req.err    = w_req_err;
                    w_nxt_cnt        = CNT_W'(WAIT_STATES);
                    w_nxt_ready      = 1'b0;
                    w_nxt_state      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_nxt_state = S_RESP;
                    w_nxt_valid = 1'b1;
                    w_nxt_rdata = w_load;
                    w_nxt_error = r_req.err;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_valid = 1'b0;
                    w_nxt_rdata = '0;
                    w_nxt_error = 1'b0;
                    w_nxt_ready = 1'b1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_req       <= w_nxt_req;
            r_cnt       <= w_nxt_cnt;
            r_req_ready <= w_nxt_ready;
            r_rsp_valid <= w_nxt_valid;
            r_rsp_rdata <= w_nxt_rdata;
            r_rsp_error <= w_nxt_error;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_error = r_rsp_error;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_STATES=2 instance at base 0 and a WAIT_STATES=0
// instance at base 0x100, selected by sel; expected responses go through a scoreboard queue.
module tb_data_mem_responder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_ready = 1'b0;

    logic        a_req_ready, a_rsp_valid, a_rsp_error;
    logic [31:0] a_rsp_rdata;
    logic        b_req_ready, b_rsp_valid, b_rsp_error;
    logic [31:0] b_rsp_rdata;

    wire         req_ready = sel ? b_req_ready : a_req_ready;
    wire         rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    wire  [31:0] rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    wire         rsp_error = sel ? b_rsp_error : a_rsp_error;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error));

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_BASE(32'h100)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid & sel), .req_ready(b_req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          er;
    } stim_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   acc_cyc  = 0;

    function automatic int exp_lat();
        return sel ? 1 : 3;
    endfunction

    // Pushes the expectation, waits for acceptance, then scrambles the request inputs.
    task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input bit er,
                         output bit to);
        int n = 0;
        exp_t e;
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        to = (req_ready !== 1'b1);
        if (to) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
            void'(sb.pop_back());
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc_cyc    = cyc;
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic collect(input bit do_ack, output logic [31:0] rd, output logic er,
                           output int lat, output bit to);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        to  = (rsp_valid !== 1'b1);
        lat = cyc - acc_cyc;
        rd  = rsp_rdata;
        er  = rsp_error;
        if (do_ack) begin
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%b valid=%b err=%b rdata=%h, required all 0",
                     req_ready, rsp_valid, rsp_error, rsp_rdata);
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b, required 0", req_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_access();
        stim_t t [16] = '{
            '{1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h0,        0},
            '{0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 0},
            '{1, 3'd0, 32'h11,  32'hAAAAAA7F, 32'h0,        0},
            '{0, 3'd2, 32'h10,  32'h0,        32'hDEAD7FEF, 0},
            '{0, 3'd0, 32'h13,  32'h0,        32'hFFFFFFDE, 0},
            '{0, 3'd4, 32'h13,  32'h0,        32'h000000DE, 0},
            '{0, 3'd1, 32'h12,  32'h0,        32'hFFFFDEAD, 0},
            '{0, 3'd5, 32'h12,  32'h0,        32'h0000DEAD, 0},
            '{0, 3'd0, 32'h11,  32'h0,        32'h0000007F, 0},
            '{1, 3'd1, 32'h12,  32'h55558001, 32'h0,        0},
            '{0, 3'd1, 32'h12,  32'h0,        32'hFFFF8001, 0},
            '{0, 3'd5, 32'h10,  32'h0,        32'h00007FEF, 0},
            '{0, 3'd2, 32'h10,  32'h0,        32'h80017FEF, 0},
            '{1, 3'd2, 32'h3FC, 32'hA5A55A5A, 32'h0,        0},
            '{0, 3'd4, 32'h3FD, 32'h0,        32'h0000005A, 0},
            '{0, 3'd2, 32'h3FC, 32'h0,        32'hA5A55A5A, 0}
        };
        logic [31:0] rd; logic er; int lat; bit to, to2; exp_t e;
        for (int i = 0; i < $size(t); i++) begin
            issue(t[i].wr, t[i].f3, t[i].addr, t[i].wd, t[i].rd, t[i].er, to);
            if (to) continue;
            collect(1'b1, rd, er, lat, to2);
            e = sb.pop_front();
            n_checks++;
            if (to2 || rd !== e.rdata || er !== e.err) begin
                n_fail++;
                $display("FAIL access[%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            n_checks++;
            if (lat != exp_lat()) begin
                n_fail++;
                $display("FAIL access_latency[%0d]: got %0d, required %0d", i, lat, exp_lat());
            end
        end
    endtask

    task automatic test_errors();
        stim_t t [12] = '{
            '{0, 3'd2, 32'h12,  32'h0,        32'h0,        1},
            '{1, 3'd1, 32'h11,  32'hFFFFFFFF, 32'h0,        1},
            '{0, 3'd2, 32'h400, 32'h0,        32'h0,        1},
            '{1, 3'd2, 32'h400, 32'h11223344, 32'h0,        1},
            '{1, 3'd2, 32'h12,  32'h11223344, 32'h0,        1},
            '{0, 3'd5, 32'h13,  32'h0,        32'h0,        1},
            '{0, 3'd2, 32'h10,  32'h0,        32'h80017FEF, 0},
            '{0, 3'd3, 32'h10,  32'h0,        32'h0,        1},
            '{1, 3'd4, 32'h10,  32'h00000000, 32'h0,        1},
            '{1, 3'd5, 32'h10,  32'h00000000, 32'h0,        1},
            '{0, 3'd7, 32'h10,  32'h0,        32'h0,        1},
            '{0, 3'd2, 32'h10,  32'h0,        32'h80017FEF, 0}
        };
        logic [31:0] rd; logic er; int lat; bit to, to2; exp_t e;
        for (int i = 0; i < $size(t); i++) begin
            issue(t[i].wr, t[i].f3, t[i].addr, t[i].wd, t[i].rd, t[i].er, to);
            if (to) continue;
            collect(1'b1, rd, er, lat, to2);
            e = sb.pop_front();
            n_checks++;
            if (to2 || rd !== e.rdata || er !== e.err) begin
                n_fail++;
                $display("FAIL error[%0d]: rdata=%h err=%b, required rdata=%h err=%b", i, rd, er, e.rdata, e.err);
            end
            n_checks++;
            if (lat != exp_lat()) begin
                n_fail++;
                $display("FAIL error_latency[%0d]: got %0d, required %0d", i, lat, exp_lat());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit to, to2; exp_t e;
        issue(1'b0, 3'd2, 32'h10, 32'h0, 32'h80017FEF, 1'b0, to);
        if (to) return;
        collect(1'b0, rd, er, lat, to2);
        e = sb.pop_front();
        n_checks++;
        if (to2 || rd !== e.rdata || er !== e.err) begin
            n_fail++;
            $display("FAIL hold_first: rdata=%h err=%b, required rdata=%h err=%b", rd, er, e.rdata, e.err);
        end
        req_valid = 1'b1;
        req_addr  = 32'h3FC;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_error !== e.err || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                         i, rsp_valid, rsp_rdata, rsp_error, req_ready, e.rdata, e.err);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'h0) begin
            n_fail++;
            $display("FAIL %s: ready=%b valid=%b err=%b rdata=%h, required all 0",
                     name, req_ready, rsp_valid, rsp_error, rsp_rdata);
        end
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Runs one fully acknowledged transaction and compares it.
    task automatic txn_check(input string name, input bit wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdx, input bit erx);
        logic [31:0] rd; logic er; int lat; bit to, to2; exp_t e;
        issue(wr, f3, addr, wd, rdx, erx, to);
        if (to) return;
        collect(1'b1, rd, er, lat, to2);
        e = sb.pop_front();
        n_checks++;
        if (to2 || rd !== e.rdata || er !== e.err || lat != exp_lat()) begin
            n_fail++;
            $display("FAIL %s: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                     name, rd, er, lat, e.rdata, e.err, exp_lat());
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        txn_check("mid_prep", 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h20, 32'h12345678, 32'h0, 1'b0, to);
        if (!to) void'(sb.pop_back());
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset_busy");
        release_reset();
        txn_check("mid_reload", 1'b0, 3'd2, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0);
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat; bit to, to2; exp_t e;
        sel = 1'b1;
        txn_check("z_below_base", 1'b0, 3'd2, 32'hFC,  32'h0, 32'h0, 1'b1);
        txn_check("z_sw_top",     1'b1, 3'd2, 32'h4FC, 32'h600DCAFE, 32'h0, 1'b0);
        txn_check("z_lw_top",     1'b0, 3'd2, 32'h4FC, 32'h0, 32'h600DCAFE, 1'b0);
        txn_check("z_above",      1'b0, 3'd2, 32'h500, 32'h0, 32'h0, 1'b1);
        txn_check("z_sw",         1'b1, 3'd2, 32'h120, 32'h11111111, 32'h0, 1'b0);
        issue(1'b1, 3'd2, 32'h120, 32'h22222222, 32'h0, 1'b0, to);
        if (!to) void'(sb.pop_back());
        reset_n = 1'b0;
        #1;
        check_reset_outputs("z_reset_busy");
        release_reset();
        txn_check("z_discarded", 1'b0, 3'd2, 32'h120, 32'h0, 32'h11111111, 1'b0);
        issue(1'b1, 3'd2, 32'h124, 32'h33333333, 32'h0, 1'b0, to);
        if (!to) begin
            collect(1'b0, rd, er, lat, to2);
            void'(sb.pop_front());
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("z_reset_resp_store");
        release_reset();
        issue(1'b0, 3'd2, 32'h124, 32'h0, 32'h33333333, 1'b0, to);
        if (!to) begin
            collect(1'b0, rd, er, lat, to2);
            e = sb.pop_front();
            n_checks++;
            if (to2 || rd !== e.rdata || er !== e.err || lat != exp_lat()) begin
                n_fail++;
                $display("FAIL z_store_kept: rdata=%h err=%b lat=%0d, required rdata=%h err=%b lat=%0d",
                         rd, er, lat, e.rdata, e.err, exp_lat());
            end
        end
        reset_n = 1'b0;
        #1;
        check_reset_outputs("z_reset_resp_load");
        release_reset();
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_access();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
